// File: rtl/bpu_pkg.sv
// Shared types and helpers for the per-PC branch predictor.
// The entry geometry below matches the predictor's default parameters
// (32-bit PC, 16 table entries, 2-bit counters); a different geometry is
// selected by changing these widths together with the top's parameters.
package bpu_pkg;

   localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;

   localparam int BPU_DATA_WIDTH = 32;
   localparam int BPU_IDX_WIDTH  = 4;
   localparam int BPU_CTR_WIDTH  = 2;

   // One in-flight prediction: where it came from, where it would go,
   // which counter produced it, and what it predicted.
   typedef struct packed {
      logic [BPU_DATA_WIDTH-1:0] pc;
      logic [BPU_DATA_WIDTH-1:0] target;
      logic [BPU_IDX_WIDTH-1:0]  idx;
      logic                      pred;
   } bpu_entry_t;

   // Step a saturating counter one place toward the observed outcome.
   function automatic logic [BPU_CTR_WIDTH-1:0] sat_update(
      input logic [BPU_CTR_WIDTH-1:0] ctr,
      input logic                     taken
   );
      if (taken)
         return (&ctr) ? ctr : ctr + 1'b1;
      else
         return (ctr == '0) ? ctr : ctr - 1'b1;
   endfunction

endpackage

// File: rtl/bpu_fifo.sv
// Fixed-depth synchronous FIFO holding in-flight branch predictions.
// Clear wins over push/pop; the caller never pushes when full or pops
// when empty, so the count never wraps.
module bpu_fifo
   import bpu_pkg::*;
#(
   parameter type T     = bpu_entry_t,
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  T                         din,
   input  logic                     pop,
   input  logic                     clear,
   output T                         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   T              mem [DEPTH];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload storage; contents are only meaningful below the count, so no reset.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign count = cnt;
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);

endmodule

// File: rtl/branch_predictor_table.sv
// Per-PC dynamic branch predictor: a table of saturating counters indexed
// by PC predicts B-type instructions at fetch, a bounded FIFO carries the
// predictions to execute, and a wrong guess produces a one-cycle redirect
// while squashing the wrong-path entries behind it.
// Optional: define BPU_PERF_CNT_EN to add saturating resolve/mispredict
// performance counters (perf_branches, perf_mispredicts).
module branch_predictor_table
   import bpu_pkg::*;
#(
   parameter int DATA_WIDTH = BPU_DATA_WIDTH,
   parameter int ENTRIES    = 16,
   parameter int CTR_WIDTH  = BPU_CTR_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] instr_f,
   input  logic [DATA_WIDTH-1:0] pc_f,
   input  logic                  stall_f,
   input  logic                  branch_e,
   input  logic                  taken_e,
   input  logic                  flush_i,
   output logic                  pred_taken_f,
   output logic [DATA_WIDTH-1:0] pred_target_f,
   output logic                  redirect_e,
   output logic [DATA_WIDTH-1:0] redirect_pc_e,
   output logic                  fifo_full,
`ifdef BPU_PERF_CNT_EN
   output logic [31:0]           perf_branches,
   output logic [31:0]           perf_mispredicts,
`endif
   output logic                  overflow_err
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   // Weakly not-taken: the largest value whose MSB is still clear.
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH-1)) - 1);

   logic [CTR_WIDTH-1:0]  ctr [ENTRIES];

   logic                  is_branch;
   logic [IDX_W-1:0]      idx_f;
   logic [DATA_WIDTH-1:0] imm_b;
   logic [DATA_WIDTH-1:0] target_f;
   logic                  pred_f;

   bpu_entry_t            new_entry;
   bpu_entry_t            head;
   logic [CNT_W-1:0]      fifo_count;
   logic                  full_w;
   logic                  fifo_empty;

   logic                  resolve;
   logic                  mispredict;
   logic                  push_req;
   logic                  push;

   // Fetch-side decode: B-type detect, table index, branch target.
   assign is_branch = (instr_f[6:0] == OPCODE_BRANCH);
   assign idx_f     = pc_f[IDX_W+1:2];
   assign imm_b     = {{(DATA_WIDTH-12){instr_f[31]}}, instr_f[7],
                       instr_f[30:25], instr_f[11:8], 1'b0};
   assign target_f  = pc_f + imm_b;
   // Lookup reads the pre-update counter; a same-cycle resolve is not bypassed.
   assign pred_f    = ctr[idx_f][CTR_WIDTH-1];

   // Execute-side resolve against the oldest in-flight prediction.
   assign resolve    = branch_e & ~fifo_empty;
   assign mispredict = resolve & (head.pred ^ taken_e);

   // A fetch behind a mispredict or flush is on the wrong path and is dropped.
   assign push_req = is_branch & ~stall_f & ~flush_i & ~mispredict;
   assign push     = push_req & ~full_w;

   assign new_entry = '{pc: pc_f, target: target_f, idx: idx_f, pred: pred_f};

   bpu_fifo #(
      .T     (bpu_entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (new_entry),
      .pop   (resolve),
      .clear (flush_i | mispredict),
      .dout  (head),
      .count (fifo_count),
      .full  (full_w),
      .empty (fifo_empty)
   );

   assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

   // Train the counter that made the prediction, using its stored index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
      end else if (resolve) begin
         ctr[head.idx] <= sat_update(ctr[head.idx], taken_e);
      end
   end

   // Registered prediction, redirect strobe and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_taken_f  <= 1'b0;
         pred_target_f <= '0;
         redirect_e    <= 1'b0;
         redirect_pc_e <= '0;
         overflow_err  <= 1'b0;
      end else begin
         pred_taken_f <= push & pred_f;
         if (push) pred_target_f <= target_f;
         redirect_e <= mispredict;
         if (mispredict)
            redirect_pc_e <= taken_e ? head.target : head.pc + DATA_WIDTH'(4);
         overflow_err <= overflow_err | (push_req & full_w) | (branch_e & fifo_empty);
      end
   end

`ifdef BPU_PERF_CNT_EN
   // Saturating event counters for resolved branches and mispredictions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (resolve && !(&perf_branches))       perf_branches    <= perf_branches + 1'b1;
         if (mispredict && !(&perf_mispredicts)) perf_mispredicts <= perf_mispredicts + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench for branch_predictor_table: a stimulus process drives one
// cycle at a time and queues the outputs the reference model expects after
// the next clock edge; an independent monitor pops and compares them.
module tb_branch_predictor_table;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr_f = '0;
   logic [31:0] pc_f = '0;
   logic        stall_f = 1'b0;
   logic        branch_e = 1'b0;
   logic        taken_e = 1'b0;
   logic        flush_i = 1'b0;
   logic        pred_taken_f;
   logic [31:0] pred_target_f;
   logic        redirect_e;
   logic [31:0] redirect_pc_e;
   logic        fifo_full;
   logic        overflow_err;
`ifdef BPU_PERF_CNT_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;
`endif

   always #5 clk = ~clk;

   branch_predictor_table dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_f       (instr_f),
      .pc_f          (pc_f),
      .stall_f       (stall_f),
      .branch_e      (branch_e),
      .taken_e       (taken_e),
      .flush_i       (flush_i),
      .pred_taken_f  (pred_taken_f),
      .pred_target_f (pred_target_f),
      .redirect_e    (redirect_e),
      .redirect_pc_e (redirect_pc_e),
      .fifo_full     (fifo_full),
`ifdef BPU_PERF_CNT_EN
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts),
`endif
      .overflow_err  (overflow_err)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned pc;
      int unsigned target;
      int          idx;
      bit          pred;
   } ent_t;

   typedef struct {
      bit          pt;
      int unsigned tgt;
      bit          rd;
      int unsigned rpc;
      bit          full;
      bit          ovf;
   } exp_t;

   ent_t        mq[$];
   int          mctr[16];
   bit          movf;
   int unsigned mtgt_hold;
   int unsigned mrpc_hold;
   exp_t        sb[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < 16; i++) mctr[i] = 1;
      movf      = 1'b0;
      mtgt_hold = 0;
      mrpc_hold = 0;
   endtask

   function automatic logic [31:0] make_br(input int off);
      logic [12:0] o;
      o = off[12:0];
      return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] make_alu();
      logic [31:0] r;
      r = $urandom;
      return {r[31:7], 7'b0010011};
   endfunction

   // Drive one cycle of inputs and queue what should appear after the edge.
   task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                       input bit st, input bit be, input bit tk, input bit fl);
      bit   empty, res, mis, isbr, preq, push, pred;
      int   idx, off;
      int unsigned tgt;
      ent_t h;
      exp_t e;
      @(negedge clk);
      instr_f = ins; pc_f = pc; stall_f = st; branch_e = be; taken_e = tk; flush_i = fl;

      empty = (mq.size() == 0);
      res   = be && !empty;
      if (res) h = mq[0];
      mis   = res && (h.pred != tk);
      isbr  = (ins[6:0] == 7'b1100011);
      preq  = isbr && !st && !fl && !mis;
      push  = preq && (mq.size() < DEPTH);
      if ((preq && mq.size() == DEPTH) || (be && empty)) movf = 1'b1;

      idx = (pc >> 2) % 16;
      pred = (mctr[idx] >= 2);
      off = 0;
      if (ins[31]) off = -4096;
      off += int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      tgt = pc + off;

      if (res) begin
         if (tk) mctr[h.idx] = (mctr[h.idx] == 3) ? 3 : mctr[h.idx] + 1;
         else    mctr[h.idx] = (mctr[h.idx] == 0) ? 0 : mctr[h.idx] - 1;
         void'(mq.pop_front());
      end
      if (fl || mis) mq.delete();
      else if (push) mq.push_back('{pc: pc, target: tgt, idx: idx, pred: pred});

      if (push) mtgt_hold = tgt;
      if (mis)  mrpc_hold = tk ? h.target : h.pc + 4;

      e.pt   = push && pred;
      e.tgt  = mtgt_hold;
      e.rd   = mis;
      e.rpc  = mrpc_hold;
      e.full = (mq.size() == DEPTH);
      e.ovf  = movf;
      sb.push_back(e);
   endtask

   task automatic idle(input bit be, input bit tk);
      step(make_alu(), 32'h200, 1'b0, be, tk, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pred_taken"},  {31'd0, pred_taken_f}, 32'd0);
      chk({tag, "_pred_target"}, pred_target_f, 32'd0);
      chk({tag, "_redirect"},    {31'd0, redirect_e}, 32'd0);
      chk({tag, "_redirect_pc"}, redirect_pc_e, 32'd0);
      chk({tag, "_full"},        {31'd0, fifo_full}, 32'd0);
      chk({tag, "_ovf"},         {31'd0, overflow_err}, 32'd0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pred_taken_f",  {31'd0, pred_taken_f}, {31'd0, e.pt});
            chk("pred_target_f", pred_target_f, e.tgt);
            chk("redirect_e",    {31'd0, redirect_e}, {31'd0, e.rd});
            if (e.rd) chk("redirect_pc_e", redirect_pc_e, e.rpc);
            chk("fifo_full",     {31'd0, fifo_full}, {31'd0, e.full});
            chk("overflow_err",  {31'd0, overflow_err}, {31'd0, e.ovf});
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // First branch at 0x100, +16: predicted not-taken, then resolved taken.
      step(make_br(16), 32'h100, 0, 0, 0, 0);
      idle(1, 1);
      idle(0, 0);

      // Train to saturation, then a not-taken outcome mispredicts.
      for (int i = 0; i < 3; i++) begin
         step(make_br(16), 32'h100, 0, 0, 0, 0);
         idle(1, 1);
      end
      step(make_br(16), 32'h100, 0, 0, 0, 0);
      idle(1, 0);
      idle(0, 0);

      // Aliasing: 0x140 shares index 0 with 0x100.
      step(make_br(32), 32'h140, 0, 0, 0, 0);
      idle(1, 0);
      step(make_br(16), 32'h100, 0, 0, 0, 0);
      idle(1, 0);

      // Three in flight, the first mispredicts, then resolve on empty.
      step(make_br(16), 32'h100, 0, 0, 0, 0);
      step(make_br(-8), 32'h104, 0, 0, 0, 0);
      step(make_br(64), 32'h108, 0, 0, 0, 0);
      idle(1, 1);
      idle(1, 0);
      idle(0, 0);

      // Push with correct resolve holds count; fill; push while full.
      step(make_br(16), 32'h110, 0, 0, 0, 0);
      step(make_br(16), 32'h114, 0, 0, 0, 0);
      step(make_br(16), 32'h118, 0, 1, 0, 0);
      step(make_br(16), 32'h11c, 0, 0, 0, 0);
      step(make_br(16), 32'h120, 0, 0, 0, 0);
      step(make_br(-4), 32'h124, 0, 0, 0, 0);
      step(make_br(16), 32'h128, 0, 0, 0, 0);
      step(make_br(16), 32'h12c, 1, 0, 0, 0);
      step(make_alu(), 32'h130, 0, 0, 0, 1);
      idle(0, 0);

      // Randomised traffic with one asynchronous reset in the middle.
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] ins, pc;
         bit st, be, tk, fl;
         pc  = 32'h100 + $urandom_range(0, 31) * 4;
         ins = ($urandom_range(0, 9) < 6) ? make_br((int'($urandom_range(0, 4095)) - 2048) * 2)
                                          : make_alu();
         st  = ($urandom_range(0, 9) == 0);
         be  = ($urandom_range(0, 9) < 4);
         tk  = $urandom_range(0, 1) == 1;
         fl  = ($urandom_range(0, 19) == 0);
         if (n == 700) begin
            step(make_br(16), 32'h100, 0, 0, 0, 0);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_zero("async_reset");
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
            instr_f = '0; branch_e = 0; flush_i = 0; stall_f = 0;
            step(make_br(16), 32'h100, 0, 0, 0, 0);
         end
         step(ins, pc, st, be, tk, fl);
      end

      // Let the monitor consume the last queued expectations.
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
